writeback_arbiter: RTL and testbench
====================================

# writeback_arbiter

Merges the two result sources of the core into the single write port of the register file: the in-order execute pipeline (fixed latency, never stalled) and the long-latency unit (loads, mul/div) with a valid/ready handshake. Long-latency results that lose arbitration are held in a small in-order buffer. The block also reports read-after-write hazards on buffered or in-flight writes so that decode can stall.

## Interface
- DATA_WIDTH, 32, register data width
- ADDR_WIDTH, 5, register address width (2**ADDR_WIDTH registers, register 0 hardwired zero)
- DEPTH, 2, long-latency buffer entries (≥1)

Ports:
- i_clock  in  1  clock, rising edge
- i_reset  in  1  reset, asynchronous, active-high
- i_pipeWr  in  1  pipeline result valid this cycle
- i_pipeAddr  in  ADDR_WIDTH  pipeline destination register
- i_pipeData  in  DATA_WIDTH  pipeline result
- i_lsuValid  in  1  long-latency result offered
- i_lsuAddr  in  ADDR_WIDTH  long-latency destination register
- i_lsuData  in  DATA_WIDTH  long-latency result
- o_lsuReady  out  1  long-latency result accepted when high with i_lsuValid
- o_wr  out  1  register file write enable
- o_wrAddr  out  ADDR_WIDTH  register file write address
- o_wrData  out  DATA_WIDTH  register file write data
- i_rdAddrA, i_rdAddrB  in  ADDR_WIDTH  decode source registers
- o_hazardA, o_hazardB  out  1  source has a pending write, decode must stall
- o_busy  out  1  buffer non-empty or o_wr high

## Operation
- Output stage is a register (o_wr/o_wrAddr/o_wrData) loaded every clock edge, priority:
  1. i_pipeWr and i_pipeAddr≠0 → pipeline result.
  2. else buffer non-empty → buffer head (popped).
  3. else LSU handshake this cycle with i_lsuAddr≠0 → LSU result directly (bypass, not buffered).
  4. else o_wr=0, address/data hold previous value.
- LSU handshake = i_lsuValid & o_lsuReady. Accepted result not forwarded by rule 3 is pushed to buffer tail. Results to register 0 are accepted and discarded.
- o_lsuReady = ~i_reset & (count < DEPTH); count is the registered occupancy, so ready does not depend on i_lsuValid or pop this cycle.
- Push and pop in same cycle: count unchanged; the pushed entry goes behind the remaining entries (FIFO order preserved).
- WAW cancellation: pipeline write with i_pipeAddr≠0 invalidates every buffered entry with the same address, and an LSU result accepted in the same cycle with the same address is discarded. Pipeline results are always younger than outstanding long-latency results. Invalidated entries still occupy their slot. When an invalidated entry reaches the head, it is popped without a write, and o_wr=0 for that slot unless rule 1 applies.
- o_hazardX = (i_rdAddrX≠0) & (matches any valid buffer entry, or (o_wr & o_wrAddr==i_rdAddrX)). Combinational. Pipeline inputs do not raise a hazard; decode handles forwarding for those.
- o_busy = (count≠0) | o_wr.

## Timing
- Reset (asynchronous): o_wr=0, o_wrAddr=0, o_wrData=0, buffer empty, all entries invalid, o_lsuReady=0 while i_reset high, o_hazardA/B=0, o_busy=0. Reset in mid-operation drops all buffered results.
- Pipeline latency: 1 cycle from i_pipeWr to o_wr. The register file captures the value on the following edge.
- LSU latency: 1 cycle when the buffer is empty and there is no pipeline write. Otherwise the result waits until the entries ahead of it drain, at most one write per cycle, in pipeline-free cycles only.
- Full: with count==DEPTH, o_lsuReady=0. It rises the cycle after a pop that leaves count<DEPTH.
- Continuous pipeline writes starve the buffer indefinitely. This is intended; the core guarantees gaps.

## Test plan
- Reset then pipe write x5=0x11 → next cycle o_wr=1, o_wrAddr=5, o_wrData=0x11; following cycle o_wr=0.
- LSU x7=0xAA alone with buffer empty → accepted, o_wr for x7 exactly 1 cycle later, count stays 0.
- Pipe x3 on 3 consecutive cycles with LSU x8=0x1, x9=0x2 offered → LSU buffered (count=2, o_lsuReady=0 next cycle), third LSU x10 held off; after the pipe stops, x8 then x9 written on successive cycles, then ready=1 and x10 accepted.
- Buffer holds x4=0xB0; pipe x4=0xC0 → o_wr x4=0xC0, buffered x4 never written; i_rdAddrA=4 gives o_hazardA=1 only until the invalid-or-written state clears.
- LSU to x0 and pipe to x0 → both produce no write, o_hazard for address 0 always 0.
- Assert i_reset asynchronously mid-cycle with 2 buffered entries → outputs clear immediately, no buffered write appears after reset release.

Source files
------------

// File: rtl/writeback_arbiter.sv
// Merges pipeline results and handshaked long-latency results into one registered register-file write port.
// One write per cycle, pipeline first; long-latency results queue in order and see o_lsuReady low while the queue is full.
module writeback_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 2
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_pipeWr,
  input  logic [ADDR_WIDTH-1:0] i_pipeAddr,
  input  logic [DATA_WIDTH-1:0] i_pipeData,
  input  logic                  i_lsuValid,
  input  logic [ADDR_WIDTH-1:0] i_lsuAddr,
  input  logic [DATA_WIDTH-1:0] i_lsuData,
  output logic                  o_lsuReady,
  output logic                  o_wr,
  output logic [ADDR_WIDTH-1:0] o_wrAddr,
  output logic [DATA_WIDTH-1:0] o_wrData,
  input  logic [ADDR_WIDTH-1:0] i_rdAddrA,
  input  logic [ADDR_WIDTH-1:0] i_rdAddrB,
  output logic                  o_hazardA,
  output logic                  o_hazardB,
  output logic                  o_busy
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]      r_vld;
  logic [CW-1:0]         r_count;
  logic                  r_wr;
  logic [ADDR_WIDTH-1:0] r_wrAddr;
  logic [DATA_WIDTH-1:0] r_wrData;

  logic                  w_pipeAct;
  logic                  w_empty;
  logic                  w_hs;
  logic                  w_pop;
  logic                  w_bypass;
  logic                  w_push;
  logic [CW-1:0]         w_tail;
  logic [CW-1:0]         w_count_n;
  logic [ADDR_WIDTH-1:0] w_addr_n [DEPTH];
  logic [DATA_WIDTH-1:0] w_data_n [DEPTH];
  logic [DEPTH-1:0]      w_vld_n;
  logic                  w_hitA;
  logic                  w_hitB;

  assign w_pipeAct  = i_pipeWr & (i_pipeAddr != '0);
  assign w_empty    = (r_count == '0);
  assign o_lsuReady = ~i_reset & (r_count < CW'(DEPTH));
  assign w_hs       = i_lsuValid & o_lsuReady;
  assign w_pop      = ~w_pipeAct & ~w_empty;
  assign w_bypass   = ~w_pipeAct & w_empty & w_hs & (i_lsuAddr != '0);
  // A same-address pipeline write is younger, so the LSU result is dead on arrival.
  assign w_push     = w_hs & (i_lsuAddr != '0) & ~w_bypass
                      & ~(w_pipeAct & (i_lsuAddr == i_pipeAddr));
  assign w_tail     = r_count - CW'(w_pop);
  assign w_count_n  = w_tail + CW'(w_push);

  // Head lives in slot 0; a pop shifts everything down one slot.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_addr_n[i] = r_addr[i];
      w_data_n[i] = r_data[i];
      w_vld_n[i]  = r_vld[i];
    end
    if (w_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        w_addr_n[i] = r_addr[i+1];
        w_data_n[i] = r_data[i+1];
        w_vld_n[i]  = r_vld[i+1];
      end
      w_vld_n[DEPTH-1] = 1'b0;
    end
    if (w_pipeAct) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_addr_n[i] == i_pipeAddr) w_vld_n[i] = 1'b0;
      end
    end
    if (w_push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) == w_tail) begin
          w_addr_n[i] = i_lsuAddr;
          w_data_n[i] = i_lsuData;
          w_vld_n[i]  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_hitA = r_wr & (r_wrAddr == i_rdAddrA);
    w_hitB = r_wr & (r_wrAddr == i_rdAddrB);
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i] && r_addr[i] == i_rdAddrA) w_hitA = 1'b1;
      if (r_vld[i] && r_addr[i] == i_rdAddrB) w_hitB = 1'b1;
    end
  end

  assign o_hazardA = (i_rdAddrA != '0) & w_hitA;
  assign o_hazardB = (i_rdAddrB != '0) & w_hitB;
  assign o_busy    = ~w_empty | r_wr;
  assign o_wr      = r_wr;
  assign o_wrAddr  = r_wrAddr;
  assign o_wrData  = r_wrData;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
      r_vld    <= '0;
      r_count  <= '0;
      r_wr     <= 1'b0;
      r_wrAddr <= '0;
      r_wrData <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= w_addr_n[i];
        r_data[i] <= w_data_n[i];
      end
      r_vld   <= w_vld_n;
      r_count <= w_count_n;
      if (w_pipeAct) begin
        r_wr     <= 1'b1;
        r_wrAddr <= i_pipeAddr;
        r_wrData <= i_pipeData;
      end else if (w_pop) begin
        // A cancelled head still consumes this slot, just without a write.
        r_wr <= r_vld[0];
        if (r_vld[0]) begin
          r_wrAddr <= r_addr[0];
          r_wrData <= r_data[0];
        end
      end else if (w_bypass) begin
        r_wr     <= 1'b1;
        r_wrAddr <= i_lsuAddr;
        r_wrData <= i_lsuData;
      end else begin
        r_wr <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomized and directed checks of writeback_arbiter against a queue-based reference model.
module tb_writeback_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          pipe_wr;
  logic [AW-1:0] pipe_addr;
  logic [DW-1:0] pipe_data;
  logic          lsu_vld;
  logic [AW-1:0] lsu_addr;
  logic [DW-1:0] lsu_data;
  logic          lsu_rdy;
  logic          wr;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] rd_a;
  logic [AW-1:0] rd_b;
  logic          haz_a;
  logic          haz_b;
  logic          busy;

  always #5 clk = ~clk;

  writeback_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .i_clock(clk), .i_reset(rst),
    .i_pipeWr(pipe_wr), .i_pipeAddr(pipe_addr), .i_pipeData(pipe_data),
    .i_lsuValid(lsu_vld), .i_lsuAddr(lsu_addr), .i_lsuData(lsu_data),
    .o_lsuReady(lsu_rdy),
    .o_wr(wr), .o_wrAddr(wr_addr), .o_wrData(wr_data),
    .i_rdAddrA(rd_a), .i_rdAddrB(rd_b),
    .o_hazardA(haz_a), .o_hazardB(haz_b),
    .o_busy(busy)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            live;
  } ent_t;

  ent_t          mq[$];
  logic          m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int            errors = 0;
  int            checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_haz(input logic [AW-1:0] rd);
    bit h;
    h = 0;
    if (rd != 0) begin
      if (m_wr && m_addr == rd) h = 1;
      foreach (mq[k]) if (mq[k].live && mq[k].addr == rd) h = 1;
    end
    return h;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_wr = 0;
    m_addr = '0;
    m_data = '0;
  endtask

  task automatic drive(input bit pw, input int pa, input int pd,
                       input bit lv, input int la, input int ld,
                       input int ra, input int rb);
    pipe_wr = pw; pipe_addr = AW'(pa); pipe_data = DW'(pd);
    lsu_vld = lv; lsu_addr = AW'(la); lsu_data = DW'(ld);
    rd_a = AW'(ra); rd_b = AW'(rb);
  endtask

  // Called shortly after a negedge with inputs already driven; returns #1 after the next posedge.
  task automatic step();
    bit   hs, pact, was_empty, bypass;
    ent_t e;
    #1;
    chk("ready", lsu_rdy, mq.size() < DEPTH);
    chk("busy", busy, (mq.size() != 0) || m_wr);
    chk("hazardA", haz_a, m_haz(rd_a));
    chk("hazardB", haz_b, m_haz(rd_b));
    hs = lsu_vld && (mq.size() < DEPTH);
    pact = pipe_wr && (pipe_addr != 0);
    was_empty = (mq.size() == 0);
    bypass = 0;
    if (pact) begin
      m_wr = 1; m_addr = pipe_addr; m_data = pipe_data;
    end else if (!was_empty) begin
      e = mq.pop_front();
      m_wr = e.live;
      if (e.live) begin m_addr = e.addr; m_data = e.data; end
    end else if (hs && lsu_addr != 0) begin
      bypass = 1;
      m_wr = 1; m_addr = lsu_addr; m_data = lsu_data;
    end else begin
      m_wr = 0;
    end
    if (pact) foreach (mq[k]) if (mq[k].addr == pipe_addr) mq[k].live = 0;
    if (hs && lsu_addr != 0 && !bypass && !(pact && lsu_addr == pipe_addr)) begin
      e.addr = lsu_addr; e.data = lsu_data; e.live = 1;
      mq.push_back(e);
    end
    @(posedge clk);
    #1;
    chk("wr", wr, m_wr);
    chk("wrAddr", wr_addr, m_addr);
    chk("wrData", wr_data, m_data);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    rst = 1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(posedge clk);
    cyc();
    #1;
    chk("rst_wr", wr, 0);
    chk("rst_addr", wr_addr, 0);
    chk("rst_data", wr_data, 0);
    chk("rst_ready", lsu_rdy, 0);
    chk("rst_busy", busy, 0);
    chk("rst_haz", haz_a, 0);
    rst = 0;

    // Pipeline write x5=0x11
    cyc(); drive(1, 5, 'h11, 0, 0, 0, 0, 0); step();
    chk("pipe_wr", wr, 1); chk("pipe_addr", wr_addr, 5); chk("pipe_data", wr_data, 'h11);
    cyc(); drive(0, 0, 0, 0, 0, 0, 0, 0); step();
    chk("pipe_wr_drop", wr, 0);

    // Lone LSU result bypasses the buffer
    cyc(); drive(0, 0, 0, 1, 7, 'hAA, 0, 0); step();
    chk("lsu_wr", wr, 1); chk("lsu_addr", wr_addr, 7); chk("lsu_data", wr_data, 'hAA);
    cyc(); drive(0, 0, 0, 0, 0, 0, 0, 0); step();
    chk("lsu_idle_busy", busy, 0);

    // Pipe x3 for three cycles while LSU offers x8, x9, x10
    cyc(); drive(1, 3, 'h30, 1, 8, 1, 0, 0); step();
    cyc(); drive(1, 3, 'h31, 1, 9, 2, 0, 0); step();
    cyc(); drive(1, 3, 'h32, 1, 10, 3, 8, 9);
    #1; chk("full_ready", lsu_rdy, 0); chk("full_hazA", haz_a, 1);
    step();
    cyc(); drive(0, 0, 0, 1, 10, 3, 0, 0); step();
    chk("drain_x8", wr_addr, 8); chk("drain_x8_data", wr_data, 1);
    cyc(); drive(0, 0, 0, 1, 10, 3, 0, 0);
    #1; chk("reopen_ready", lsu_rdy, 1);
    step();
    chk("drain_x9", wr_addr, 9);
    cyc(); drive(0, 0, 0, 0, 0, 0, 0, 0); step();
    chk("drain_x10", wr_addr, 10); chk("drain_x10_wr", wr, 1);

    // WAW cancellation of buffered x4
    cyc(); drive(1, 1, 'h1, 1, 4, 'hB0, 4, 0); step();
    cyc(); drive(1, 4, 'hC0, 0, 0, 0, 4, 0);
    #1; chk("waw_haz_buf", haz_a, 1);
    step();
    chk("waw_addr", wr_addr, 4); chk("waw_data", wr_data, 'hC0);
    cyc(); drive(0, 0, 0, 0, 0, 0, 4, 0);
    #1; chk("waw_haz_owr", haz_a, 1);
    step();
    chk("waw_no_write", wr, 0);
    cyc(); drive(0, 0, 0, 0, 0, 0, 4, 0);
    #1; chk("waw_haz_clear", haz_a, 0);
    step();

    // Register 0 is never written or hazarded
    cyc(); drive(1, 0, 'h55, 1, 0, 'h66, 0, 0); step();
    chk("x0_no_write", wr, 0);
    cyc(); drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1; chk("x0_haz", haz_a, 0); chk("x0_busy", busy, 0);
    step();

    // Async reset with two buffered entries
    cyc(); drive(1, 2, 'h2, 1, 12, 'hC, 0, 0); step();
    cyc(); drive(1, 2, 'h3, 1, 13, 'hD, 0, 0); step();
    cyc(); drive(0, 0, 0, 0, 0, 0, 12, 13);
    #2; rst = 1; #1;
    chk("arst_wr", wr, 0); chk("arst_busy", busy, 0); chk("arst_ready", lsu_rdy, 0);
    chk("arst_hazA", haz_a, 0); chk("arst_hazB", haz_b, 0);
    model_reset();
    @(posedge clk);
    cyc(); rst = 0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) cyc();
      step();
      chk("arst_no_write", wr, 0);
    end

    // Randomized traffic with small address range to provoke collisions
    for (int i = 0; i < 3000; i++) begin
      cyc();
      drive($urandom_range(0, 99) < 45, $urandom_range(0, 7), $urandom,
            $urandom_range(0, 99) < 60, $urandom_range(0, 7), $urandom,
            $urandom_range(0, 7), $urandom_range(0, 7));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
